// File: rtl/filt_out_buf.sv
// -----------------------------------------------------------------------------
// filt_out_buf
//
// Output buffer for the 4-bit IIR filter stage. Every sample strobed by
// y_is_valid is captured into a small FIFO and handed to the consumer over a
// valid/ready handshake, so a stalling consumer does not lose samples (up to
// DEPTH of them). Dropped samples raise a sticky overflow flag. The block also
// reports the peak sample over consecutive windows of WIN accepted samples.
//
// Parameters:
//   W      sample width (matches the filter output width)
//   DEPTH  FIFO depth in samples, power of 2, >= 2
//   WIN    peak window length in accepted samples, >= 1
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   y           filtered sample, unsigned
//   y_is_valid  sample strobe, at most one per cycle
//   d_out       sample at the FIFO head (meaningful while d_valid)
//   d_valid     FIFO non-empty
//   d_ready     consumer takes the head sample when d_valid & d_ready
//   level       FIFO occupancy, 0..DEPTH
//   overflow    sticky: a sample was dropped since reset
//   peak        maximum of the last completed window
//   peak_valid  one-cycle pulse when peak updates
// -----------------------------------------------------------------------------
module filt_out_buf #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  parameter int WIN   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               y,
  input  logic                       y_is_valid,
  output logic [W-1:0]               d_out,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [W-1:0]               peak,
  output logic                       peak_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // A window of one sample still needs a counter bit to compare against.
  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] WIN_LAST   = CW'(WIN - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  logic [W-1:0]  run_max;
  logic [CW-1:0] win_cnt;
  logic [W-1:0]  win_max;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign full = (level == LEVEL_FULL);
  assign pop  = d_valid & d_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = y_is_valid & (~full | pop);
  assign drop = y_is_valid & full & ~pop;

  // No bypass: the head is always read from storage.
  assign d_out = mem[rd_ptr];

  // Running max including the sample being accepted this cycle.
  assign win_max = (y > run_max) ? y : run_max;

  // NOTE: combinational blocks use blocking '=' and assign a default first so
  // no path leaves level_next unassigned (which would infer a latch).
  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; its contents are only
  // observable through d_out while d_valid is set, and leaving it out of the
  // reset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= y;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and status
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      d_valid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // DEPTH is a power of 2, so pointer wrap is the natural rollover.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level   <= level_next;
      d_valid <= (level_next != '0);
      if (drop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Peak tracking over windows of accepted samples
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max    <= '0;
      win_cnt    <= '0;
      peak       <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (push) begin
        if (win_cnt == WIN_LAST) begin
          peak       <= win_max;
          peak_valid <= 1'b1;
          run_max    <= '0;
          win_cnt    <= '0;
        end else begin
          run_max <= win_max;
          win_cnt <= win_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_filt_out_buf.sv
// -----------------------------------------------------------------------------
// tb_filt_out_buf
//
// Directed testbench for filt_out_buf with default parameters (W=4, DEPTH=8,
// WIN=16). Inputs change 1 ns after the rising edge; outputs are sampled at
// that same point, so each observation reflects the preceding edge.
// -----------------------------------------------------------------------------
module tb_filt_out_buf;

  localparam int W     = 4;
  localparam int DEPTH = 8;
  localparam int WIN   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  y;
  logic          y_is_valid;
  logic [W-1:0]  d_out;
  logic          d_valid;
  logic          d_ready;
  logic [LW-1:0] level;
  logic          overflow;
  logic [W-1:0]  peak;
  logic          peak_valid;

  int checks   = 0;
  int failures = 0;

  filt_out_buf #(.W(W), .DEPTH(DEPTH), .WIN(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .y          (y),
    .y_is_valid (y_is_valid),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .level      (level),
    .overflow   (overflow),
    .peak       (peak),
    .peak_valid (peak_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] val);
    y          = val;
    y_is_valid = 1'b1;
    step();
    y_is_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    y_is_valid = 1'b0;
    d_ready    = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    int pulses;

    rst        = 1'b1;
    y          = '0;
    y_is_valid = 1'b0;
    d_ready    = 1'b0;

    // ---- Reset then idle ----------------------------------------------------
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_d_valid",    32'(d_valid),    32'd0);
    chk("rst_level",      32'(level),      32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_peak",       32'(peak),       32'd0);
    chk("rst_peak_valid", 32'(peak_valid), 32'd0);
    d_ready = 1'b1;
    step();
    chk("ready_empty_level", 32'(level),   32'd0);
    chk("ready_empty_valid", 32'(d_valid), 32'd0);

    // ---- Streaming pass-through --------------------------------------------
    do_reset();
    d_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push(W'(k));
      chk("stream_d_valid", 32'(d_valid), 32'd1);
      chk("stream_d_out",   32'(d_out),   32'(k));
      chk("stream_level",   32'(level),   32'd1);
    end
    step();
    chk("stream_drained_level", 32'(level),    32'd0);
    chk("stream_drained_valid", 32'(d_valid),  32'd0);
    chk("stream_overflow",      32'(overflow), 32'd0);

    // ---- Fill and overflow ---------------------------------------------------
    do_reset();
    for (int k = 0; k < DEPTH; k++) push(W'(k));
    chk("fill_level",       32'(level),    32'd8);
    chk("fill_no_overflow", 32'(overflow), 32'd0);
    push(W'(8));
    chk("ovf_level",    32'(level),    32'd8);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    d_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_d_out", 32'(d_out), 32'(k));
      step();
    end
    chk("drain_level",    32'(level),    32'd0);
    chk("drain_d_valid",  32'(d_valid),  32'd0);
    chk("drain_overflow", 32'(overflow), 32'd1);
    step();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // ---- Simultaneous push/pop at full ---------------------------------------
    do_reset();
    chk("pp_rst_overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < DEPTH; k++) push(W'(k));
    chk("pp_full_level", 32'(level), 32'd8);
    d_ready = 1'b1;
    push(4'hA);
    chk("pp_level",    32'(level),    32'd8);
    chk("pp_overflow", 32'(overflow), 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      chk("pp_drain_d_out", 32'(d_out), (k == DEPTH) ? 32'hA : 32'(k));
      step();
    end
    chk("pp_drain_level", 32'(level), 32'd0);

    // ---- Peak windows --------------------------------------------------------
    do_reset();
    d_ready = 1'b1;
    for (int k = 0; k < WIN; k++) begin
      v = (k == 5) ? 4'hC : W'(k);
      push(v);
      chk("win1_peak_valid", 32'(peak_valid), (k == WIN - 1) ? 32'd1 : 32'd0);
    end
    chk("win1_peak", 32'(peak), 32'hF);
    step();
    chk("win1_pulse_end", 32'(peak_valid), 32'd0);
    chk("win1_peak_hold", 32'(peak),       32'hF);
    for (int k = 0; k < WIN; k++) begin
      push(4'h3);
      chk("win2_peak_valid", 32'(peak_valid), (k == WIN - 1) ? 32'd1 : 32'd0);
    end
    chk("win2_peak", 32'(peak), 32'h3);

    // ---- Reset mid-window ----------------------------------------------------
    do_reset();
    d_ready = 1'b1;
    for (int k = 0; k < 10; k++) push((k == 4) ? 4'hE : 4'h1);
    // Sample and ready presented during reset must be ignored.
    rst        = 1'b1;
    y          = 4'hF;
    y_is_valid = 1'b1;
    step();
    rst        = 1'b0;
    y_is_valid = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_peak",  32'(peak),  32'd0);
    pulses = 0;
    for (int k = 0; k < WIN; k++) begin
      push(4'h2);
      if (peak_valid) pulses++;
      chk("mid_peak_valid", 32'(peak_valid), (k == WIN - 1) ? 32'd1 : 32'd0);
    end
    chk("mid_peak",   32'(peak), 32'h2);
    chk("mid_pulses", 32'(pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
